// File: rtl/pll_cfg_pkg.sv
// Shared types and register map constants for the PLL configuration bank.
// Offsets are word offsets inside a channel's 16-byte window.
package pll_cfg_pkg;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_t;

  localparam int CH_STRIDE = 16;

  localparam logic [1:0] OFF_KP   = 2'd0;
  localparam logic [1:0] OFF_KI   = 2'd1;
  localparam logic [1:0] OFF_DIV  = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_RAMP = 1;

  function automatic logic [31:0] wmerge(
    logic [31:0] old,
    logic [31:0] data,
    logic [3:0]  strobe
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_cfg_bank_if.sv
// Register bus between the AHB slave front end and the PLL bank.
// Read data and error are combinational in the request cycle.
interface pll_cfg_bank_if;
  logic        wen;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        error;
  logic        request_stall;

  modport master (
    output wen, ren, addr, wdata, strobe,
    input  rdata, error, request_stall
  );

  modport slave (
    input  wen, ren, addr, wdata, strobe,
    output rdata, error, request_stall
  );
endinterface

// File: rtl/pll_glide_ch.sv
// One PLL channel: divider target plus the applied divider, which
// glides one step per RAMP_DIV cycles when ramping is enabled.
module pll_glide_ch
  import pll_cfg_pkg::*;
#(
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(72),
  parameter int               RAMP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DIV_W-1:0] wd,
  input  logic             ramp_en,
  input  logic             enable,
  output logic [DIV_W-1:0] target,
  output logic [DIV_W-1:0] div,
  output logic             busy
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  ramp_state_t      state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [DIV_W-1:0] tgt, div_n, step;
  logic             glide;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= DIV_RST;
      div    <= DIV_RST;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      target <= tgt;
      div    <= div_n;
    end
  end

  // The incoming write is seen immediately so a glide starts in the write cycle.
  always_comb begin
    tgt     = we ? wd : target;
    glide   = ramp_en & enable;
    step    = (tgt > div) ? div + 1'b1 : div - 1'b1;
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    unique case (state)
      IDLE: begin
        if (glide && tgt != div) begin
          state_n = RAMP;
          cnt_n   = '0;
        end else begin
          div_n = tgt;
        end
      end
      RAMP: begin
        if (!glide) begin
          div_n   = tgt;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (tgt == div) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          div_n = step;
          cnt_n = '0;
          if (step == tgt) state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  assign busy = (state == RAMP);

endmodule

// File: rtl/pll_cfg_bank.sv
// N-channel PLL configuration bank: KP/KI/DIV/CTRL per channel,
// divider glide channels and live/sticky lock status.
module pll_cfg_bank
  import pll_cfg_pkg::*;
#(
  parameter int               NUM_CH   = 1,
  parameter int               KP_W     = 16,
  parameter logic [KP_W-1:0]  KP_RST   = KP_W'(16'h0100),
  parameter int               KI_W     = 16,
  parameter logic [KI_W-1:0]  KI_RST   = KI_W'(16'h0008),
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(72),
  parameter int               RAMP_DIV = 4
) (
  input  logic                      h_clk,
  input  logic                      h_reset,
  pll_cfg_bank_if.slave             bus,
  input  logic [NUM_CH-1:0]         lock_i,
  output logic [NUM_CH*KP_W-1:0]    kp_o,
  output logic [NUM_CH*KI_W-1:0]    ki_o,
  output logic [NUM_CH*DIV_W-1:0]   div_o,
  output logic [NUM_CH-1:0]         en_o,
  output logic [NUM_CH-1:0]         busy_o
);

  localparam int STAT_W = CH_STRIDE / 4 * NUM_CH;

  logic [KP_W-1:0]  kp     [NUM_CH];
  logic [KI_W-1:0]  ki     [NUM_CH];
  logic [1:0]       ctrl   [NUM_CH];
  logic [DIV_W-1:0] target [NUM_CH];
  logic [DIV_W-1:0] div_new[NUM_CH];

  logic [29:0]       word;
  logic [1:0]        off;
  logic [2:0]        ch;
  logic              is_stat, bad_addr, div_zero;
  logic              err, wr_ok;
  logic [31:0]       rd_val, wmask, wm;
  logic [NUM_CH-1:0] sel, tgt_we, busy, lost, lock_q;
  logic [NUM_CH-1:0] lost_set, lost_clr;
  logic              unused_ok;

  assign word      = bus.addr[31:2];
  assign off       = bus.addr[3:2];
  assign ch        = bus.addr[6:4];
  assign unused_ok = ^bus.addr[1:0];
  assign is_stat   = (word == 30'(STAT_W));
  assign bad_addr  = (word > 30'(STAT_W));

  assign wmask = {{8{bus.strobe[3]}}, {8{bus.strobe[2]}},
                  {8{bus.strobe[1]}}, {8{bus.strobe[0]}}};
  assign wm    = bus.wdata & wmask;

  always_comb begin
    sel      = '0;
    rd_val   = '0;
    div_zero = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      div_new[c] = DIV_W'(wmerge(32'(target[c]), bus.wdata, bus.strobe));
      if (!bad_addr && !is_stat && ch == 3'(c)) sel[c] = 1'b1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        unique case (off)
          OFF_KP:   rd_val = 32'(kp[c]);
          OFF_KI:   rd_val = 32'(ki[c]);
          OFF_DIV: begin
            rd_val   = 32'(target[c]);
            div_zero = (div_new[c] == '0);
          end
          OFF_CTRL: rd_val = 32'(ctrl[c]);
        endcase
      end
    end
    if (is_stat) rd_val = 32'({lost, lock_i, busy});
  end

  assign err   = ((bus.wen | bus.ren) & bad_addr) | (bus.wen & div_zero);
  assign wr_ok = bus.wen & ~err;

  assign bus.error         = err;
  assign bus.rdata         = (bus.ren && !err) ? rd_val : '0;
  assign bus.request_stall = 1'b0;

  // Lock loss only counts on an enabled channel that is not gliding.
  assign lost_set = lock_q & ~lock_i & en_o & ~busy;
  assign lost_clr = (wr_ok && is_stat) ? wm[3*NUM_CH-1:2*NUM_CH] : '0;

  always_ff @(posedge h_clk) begin
    if (h_reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        kp[c]   <= KP_RST;
        ki[c]   <= KI_RST;
        ctrl[c] <= '0;
      end
      lost   <= '0;
      lock_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok && sel[c]) begin
          case (off)
            OFF_KP:   kp[c]   <= KP_W'(wmerge(32'(kp[c]), bus.wdata, bus.strobe));
            OFF_KI:   ki[c]   <= KI_W'(wmerge(32'(ki[c]), bus.wdata, bus.strobe));
            OFF_DIV:  ;
            OFF_CTRL: ctrl[c] <= 2'(wmerge(32'(ctrl[c]), bus.wdata, bus.strobe));
          endcase
        end
      end
      lost   <= (lost & ~lost_clr) | lost_set;
      lock_q <= lock_i;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign tgt_we[g] = wr_ok & sel[g] & (off == OFF_DIV);

    pll_glide_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST),
      .RAMP_DIV(RAMP_DIV)
    ) u_ch (
      .clk    (h_clk),
      .rst    (h_reset),
      .we     (tgt_we[g]),
      .wd     (div_new[g]),
      .ramp_en(ctrl[g][CTRL_RAMP]),
      .enable (ctrl[g][CTRL_EN]),
      .target (target[g]),
      .div    (div_o[g*DIV_W +: DIV_W]),
      .busy   (busy[g])
    );

    assign kp_o[g*KP_W +: KP_W] = kp[g];
    assign ki_o[g*KI_W +: KI_W] = ki[g];
    assign en_o[g]              = ctrl[g][CTRL_EN];
  end

  assign busy_o = busy;

endmodule

// File: tb/tb_pll_cfg_bank.sv
// Scoreboard bench for pll_cfg_bank: a timestamp-based reference model
// predicts every cycle; a negedge monitor pops and compares.
module tb_pll_cfg_bank;

  localparam int N    = 2;
  localparam int RD   = 4;
  localparam int KW   = 16;
  localparam int DW   = 8;
  localparam int STAT = 4 * N;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    lock = '0;
  logic [N*KW-1:0] kp_o, ki_o;
  logic [N*DW-1:0] div_o;
  logic [N-1:0]    en_o, busy_o;

  pll_cfg_bank_if bus ();

  pll_cfg_bank #(.NUM_CH(N), .RAMP_DIV(RD)) dut (
    .h_clk  (clk),
    .h_reset(rst),
    .bus    (bus),
    .lock_i (lock),
    .kp_o   (kp_o),
    .ki_o   (ki_o),
    .div_o  (div_o),
    .en_o   (en_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     rd;
    logic            err;
    logic [N*DW-1:0] div;
    logic [N-1:0]    busy;
    logic [N-1:0]    en;
    logic [N*KW-1:0] kp;
    logic [N*KW-1:0] ki;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscmp  = 0;
  int cyc     = 0;
  logic [N-1:0] lk_v = '0;

  // Reference state: registers as plain numbers, glides as step deadlines.
  int unsigned m_kp[N], m_ki[N], m_tgt[N], m_div[N], m_ctrl[N];
  bit          m_busy[N];
  int          m_due[N];
  bit [N-1:0]  m_lost, m_lprev;

  function automatic int unsigned merge(int unsigned old, logic [31:0] d, logic [3:0] s);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return (old & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_kp[c] = 'h100; m_ki[c] = 8; m_tgt[c] = 72; m_div[c] = 72;
      m_ctrl[c] = 0; m_busy[c] = 0; m_due[c] = 0;
    end
    m_lost = '0; m_lprev = '0;
  endtask

  function automatic int unsigned status(logic [N-1:0] lk);
    int unsigned v = 0;
    for (int c = 0; c < N; c++) begin
      if (m_busy[c]) v = v | (1 << c);
      if (lk[c])     v = v | (1 << (N + c));
      if (m_lost[c]) v = v | (1 << (2 * N + c));
    end
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp, int at);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, at, act, exp);
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input bit rs);
    exp_t e;
    int kind, ch, off, now;
    int unsigned w_idx, nt, rv;
    int unsigned t[N];
    bit err, wr;
    bit [N-1:0] set, clr;
    @(posedge clk); #1;
    bus.wen = w; bus.ren = r; bus.addr = a; bus.wdata = d; bus.strobe = s;
    lock = lk_v; rst = rs;
    w_idx = a >> 2;
    ch = 0; off = 0;
    if (w_idx > STAT) kind = 2;
    else if (w_idx == STAT) kind = 1;
    else begin kind = 0; ch = int'(w_idx / 4); off = int'(w_idx % 4); end
    nt = (kind == 0) ? (merge(m_tgt[ch], d, s) & 'hFF) : 1;
    err = ((w || r) && kind == 2) || (w && kind == 0 && off == 2 && nt == 0);
    rv = 0;
    if (r && !err) begin
      if (kind == 1) rv = status(lk_v);
      else if (kind == 0) begin
        case (off)
          0: rv = m_kp[ch];
          1: rv = m_ki[ch];
          2: rv = m_tgt[ch];
          default: rv = m_ctrl[ch];
        endcase
      end
    end
    e.rd = rv; e.err = err; e.cyc = cyc;
    for (int c = 0; c < N; c++) begin
      e.div[c*DW +: DW] = DW'(m_div[c]);
      e.busy[c] = m_busy[c];
      e.en[c]   = m_ctrl[c][0];
      e.kp[c*KW +: KW] = KW'(m_kp[c]);
      e.ki[c*KW +: KW] = KW'(m_ki[c]);
    end
    q.push_back(e);
    now = cyc;
    cyc++;
    if (rs) begin model_reset(); return; end
    wr = w && !err;
    set = '0; clr = '0;
    for (int c = 0; c < N; c++)
      if (m_lprev[c] && !lk_v[c] && (m_ctrl[c] & 1) != 0 && !m_busy[c]) set[c] = 1'b1;
    if (wr && kind == 1) clr = N'(merge(0, d, s) >> (2 * N));
    m_lost = (m_lost & ~clr) | set;
    m_lprev = lk_v;
    for (int c = 0; c < N; c++) begin
      bit on;
      t[c] = (wr && kind == 0 && off == 2 && ch == c) ? nt : m_tgt[c];
      on = (m_ctrl[c] == 3);
      if (!m_busy[c]) begin
        if (on && t[c] != m_div[c]) begin m_busy[c] = 1; m_due[c] = now + RD; end
        else m_div[c] = t[c];
      end else if (!on) begin
        m_div[c] = t[c]; m_busy[c] = 0;
      end else if (m_div[c] == t[c]) begin
        m_busy[c] = 0;
      end else if (now == m_due[c]) begin
        if (t[c] > m_div[c]) m_div[c]++; else m_div[c]--;
        m_due[c] = now + RD;
        if (m_div[c] == t[c]) m_busy[c] = 0;
      end
      m_tgt[c] = t[c];
    end
    if (wr && kind == 0) begin
      case (off)
        0: m_kp[ch] = merge(m_kp[ch], d, s) & 'hFFFF;
        1: m_ki[ch] = merge(m_ki[ch], d, s) & 'hFFFF;
        3: m_ctrl[ch] = merge(m_ctrl[ch], d, s) & 3;
        default: ;
      endcase
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s = 4'hF);
    step(1, 0, a, d, s, 0);
  endtask

  task automatic rd(logic [31:0] a);
    step(0, 1, a, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (bus.wen || bus.ren) begin
          chk("rdata", 64'(bus.rdata), 64'(e.rd), e.cyc);
          chk("error", 64'(bus.error), 64'(e.err), e.cyc);
        end
        chk("div_o", 64'(div_o), 64'(e.div), e.cyc);
        chk("busy_o", 64'(busy_o), 64'(e.busy), e.cyc);
        chk("en_o", 64'(en_o), 64'(e.en), e.cyc);
        chk("kp_o", 64'(kp_o), 64'(e.kp), e.cyc);
        chk("ki_o", 64'(ki_o), 64'(e.ki), e.cyc);
        chk("stall", 64'(bus.request_stall), 64'd0, e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bus.wen = 0; bus.ren = 0; bus.addr = 0; bus.wdata = 0; bus.strobe = 0;
    repeat (2) @(posedge clk);
    model_reset();
    idle(1);
    rd('h0); rd('h4); rd('h8); rd('hC); rd('h20);
    wr('hC, 3);
    wr('h8, 76);
    idle(20);
    wr('h8, 74);
    idle(10);
    wr('h8, 74);
    idle(2);
    wr('h8, 70);
    idle(6);
    wr('h8, 80);
    idle(60);
    wr('h1C, 1);
    wr('h18, 100);
    idle(3);
    wr('h8, 0);
    rd('h8);
    rd('h24);
    wr('h24, 5);
    wr('h0, 'hABCD, 4'b0001);
    rd('h0);
    wr('h4, 'h1234_5678, 4'b0010);
    rd('h4);
    lk_v = 2'b11; idle(2);
    lk_v = 2'b10; idle(2);
    rd('h20);
    wr('h20, 'h10);
    rd('h20);
    wr('h8, 90);
    idle(6);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    rd('h8);
    for (int i = 0; i < 3000; i++) begin
      int r;
      int unsigned wi;
      logic [31:0] a, d;
      logic [3:0] s;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 11) == 0) lk_v = lk_v ^ N'($urandom_range(1, 3));
      wi = $urandom_range(0, STAT + 2);
      if ($urandom_range(0, 30) == 0) wi = 16;
      if (wi < STAT && wi % 4 == 3) wi = ($urandom_range(0, 3) != 0) ? wi : wi - 1;
      a = (wi << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      if (wi < STAT && wi % 4 == 2)
        d[7:0] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'(60 + $urandom_range(0, 16));
      if (wi < STAT && wi % 4 == 3 && $urandom_range(0, 3) != 0) d[1:0] = 2'b11;
      s = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      if (r < 1) step(0, 0, 0, 0, 0, 1);
      else if (r < 40) idle(1);
      else if (r < 70) step(0, 1, a, 0, 0, 0);
      else step(1, ($urandom_range(0, 7) == 0), a, d, s, 0);
    end
    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      miscmp++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
